// File: rtl/pc_stack_seq.sv
// Program-counter sequencer for the 12-bit-instruction core: decodes GOTO/CALL/RETLW/PC-write,
// keeps return addresses on a DEPTH-entry LIFO with discard or circular overflow, and sticky error flags.
module pc_stack_seq #(
  parameter int              PC_W         = 11,
  parameter int              K_W          = 8,
  parameter int              FIN_W        = 8,
  parameter int              DEPTH        = 2,
  parameter int              OVF_MODE     = 0,
  parameter logic [PC_W-1:0] RESET_VECTOR = '1
) (
  input  logic                           clk4,
  input  logic                           reset,
  input  logic                           en,
  input  logic [11:0]                    inst,
  input  logic [K_W-1:0]                 k,
  input  logic [FIN_W-1:0]               fin,
  input  logic                           err_clr,
  output logic [PC_W-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           ovf_err,
  output logic                           unf_err
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = LVL_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] base_q, base_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  stack_q [DEPTH];

  logic             is_goto, is_call, is_ret, is_pcw;
  logic             full, empty;
  logic             push_en, ovf_set, unf_set;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  stack_top;
  logic [PTR_W-1:0] push_idx, top_idx;
  logic [DEPTH-1:0] wr_en;

  // Physical slot of a logical position, reduced modulo DEPTH (inputs are always < 2*DEPTH).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] r;
    r = (s >= SUM_W'(DEPTH)) ? s - SUM_W'(DEPTH) : s;
    return PTR_W'(r);
  endfunction

  assign is_goto = (inst[11:9] == 3'b101);
  assign is_call = (inst[11:8] == 4'b1001);
  assign is_ret  = (inst[11:8] == 4'b1000);
  assign is_pcw  = (inst == 12'h222) || (inst == 12'h1E2);

  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign pc_inc = pc_q + PC_W'(1);

  // base_q marks the oldest entry; it only moves when a circular push overwrites it.
  assign push_idx  = wrap_idx(SUM_W'(base_q) + SUM_W'(level_q));
  assign top_idx   = wrap_idx(SUM_W'(base_q) + SUM_W'(empty ? DEPTH_L : level_q) - SUM_W'(1));
  assign stack_top = stack_q[top_idx];

  always_comb begin
    pc_d    = pc_q;
    level_d = level_q;
    base_d  = base_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      pc_d = pc_inc;
      if (is_goto) begin
        pc_d = PC_W'(k);
      end else if (is_call) begin
        pc_d = PC_W'(k);
        if (full) begin
          ovf_set = 1'b1;
          if (OVF_MODE == 1) begin
            push_en = 1'b1;
            base_d  = wrap_idx(SUM_W'(base_q) + SUM_W'(1));
          end
        end else begin
          push_en = 1'b1;
          level_d = level_q + LVL_W'(1);
        end
      end else if (is_ret) begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          pc_d    = stack_top;
          level_d = level_q - LVL_W'(1);
        end
      end else if (is_pcw) begin
        pc_d = PC_W'(fin);
      end
    end
  end

  // A new error in the clearing cycle wins over err_clr.
  assign ovf_d = ovf_set | (ovf_q & ~err_clr);
  assign unf_d = unf_set | (unf_q & ~err_clr);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = push_en && (push_idx == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) stack_q[i] <= pc_inc;
      end
    end
  end

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      level_q <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc          = pc_q;
  assign level       = level_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Bench for pc_stack_seq: discard-mode and circular-mode instances share stimulus;
// expected results are queued per instruction and popped after the clock edge.
module tb_pc_stack_seq;

  logic        clk4 = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] inst = 12'h000;
  logic [7:0]  k = 8'h00;
  logic [7:0]  fin = 8'h00;

  logic [10:0] pc_m0, pc_m1;
  logic [1:0]  lvl_m0, lvl_m1;
  logic        full_m0, full_m1, empty_m0, empty_m1;
  logic        ovf_m0, ovf_m1, unf_m0, unf_m1;

  pc_stack_seq #(.OVF_MODE(0)) u_m0 (
    .clk4(clk4), .reset(reset), .en(en), .inst(inst), .k(k), .fin(fin), .err_clr(err_clr),
    .pc(pc_m0), .level(lvl_m0), .stack_full(full_m0), .stack_empty(empty_m0),
    .ovf_err(ovf_m0), .unf_err(unf_m0)
  );

  pc_stack_seq #(.OVF_MODE(1)) u_m1 (
    .clk4(clk4), .reset(reset), .en(en), .inst(inst), .k(k), .fin(fin), .err_clr(err_clr),
    .pc(pc_m1), .level(lvl_m1), .stack_full(full_m1), .stack_empty(empty_m1),
    .ovf_err(ovf_m1), .unf_err(unf_m1)
  );

  always #5 clk4 = ~clk4;

  localparam logic [11:0] NOP  = 12'h000;
  localparam logic [11:0] GOTO = 12'hA00;
  localparam logic [11:0] CALL = 12'h900;
  localparam logic [11:0] RET  = 12'h800;

  typedef struct {
    string tag;
    int    pc0, l0, o0, u0;
    int    pc1, l1, o1, u1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t x;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 0, 1);
    end else begin
      x = exp_q.pop_front();
      check_val({x.tag, ".m0.pc"},    int'(pc_m0),    x.pc0);
      check_val({x.tag, ".m0.level"}, int'(lvl_m0),   x.l0);
      check_val({x.tag, ".m0.full"},  int'(full_m0),  (x.l0 == 2) ? 1 : 0);
      check_val({x.tag, ".m0.empty"}, int'(empty_m0), (x.l0 == 0) ? 1 : 0);
      check_val({x.tag, ".m0.ovf"},   int'(ovf_m0),   x.o0);
      check_val({x.tag, ".m0.unf"},   int'(unf_m0),   x.u0);
      check_val({x.tag, ".m1.pc"},    int'(pc_m1),    x.pc1);
      check_val({x.tag, ".m1.level"}, int'(lvl_m1),   x.l1);
      check_val({x.tag, ".m1.full"},  int'(full_m1),  (x.l1 == 2) ? 1 : 0);
      check_val({x.tag, ".m1.empty"}, int'(empty_m1), (x.l1 == 0) ? 1 : 0);
      check_val({x.tag, ".m1.ovf"},   int'(ovf_m1),   x.o1);
      check_val({x.tag, ".m1.unf"},   int'(unf_m1),   x.u1);
      $display("step %-10s pc0=%03h lvl0=%0d ovf0=%0b unf0=%0b | pc1=%03h lvl1=%0d ovf1=%0b unf1=%0b",
               x.tag, pc_m0, lvl_m0, ovf_m0, unf_m0, pc_m1, lvl_m1, ovf_m1, unf_m1);
    end
  endtask

  task automatic step(input string tag, input logic [11:0] i, input logic [7:0] kk,
                      input logic [7:0] ff, input logic e, input logic c,
                      input int pc0, input int l0, input int o0, input int u0,
                      input int pc1, input int l1, input int o1, input int u1);
    exp_t x;
    inst = i; k = kk; fin = ff; en = e; err_clr = c;
    x.tag = tag;
    x.pc0 = pc0; x.l0 = l0; x.o0 = o0; x.u0 = u0;
    x.pc1 = pc1; x.l1 = l1; x.o1 = o1; x.u1 = u1;
    exp_q.push_back(x);
    @(posedge clk4);
    #1;
    check_outputs();
  endtask

  task automatic stepb(input string tag, input logic [11:0] i, input logic [7:0] kk,
                       input logic [7:0] ff, input logic e, input logic c,
                       input int p, input int l, input int o, input int u);
    step(tag, i, kk, ff, e, c, p, l, o, u, p, l, o, u);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".m0.pc"},    int'(pc_m0),    'h7FF);
    check_val({tag, ".m0.level"}, int'(lvl_m0),   0);
    check_val({tag, ".m0.empty"}, int'(empty_m0), 1);
    check_val({tag, ".m0.flags"}, int'({ovf_m0, unf_m0}), 0);
    check_val({tag, ".m1.pc"},    int'(pc_m1),    'h7FF);
    check_val({tag, ".m1.level"}, int'(lvl_m1),   0);
    check_val({tag, ".m1.flags"}, int'({ovf_m1, unf_m1}), 0);
    $display("reset %s pc0=%03h pc1=%03h", tag, pc_m0, pc_m1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_state("reset_init");
    reset = 1'b0;

    // Wrap out of the reset vector
    stepb("nop_wrap", NOP, 8'h00, 8'h00, 1, 0, 'h000, 0, 0, 0);
    stepb("nop1",     NOP, 8'h00, 8'h00, 1, 0, 'h001, 0, 0, 0);
    stepb("nop2",     NOP, 8'h00, 8'h00, 1, 0, 'h002, 0, 0, 0);

    // Nested call/return
    stepb("goto10",   GOTO, 8'h10, 8'h00, 1, 0, 'h010, 0, 0, 0);
    stepb("call40",   CALL, 8'h40, 8'h00, 1, 0, 'h040, 1, 0, 0);
    stepb("call80",   CALL, 8'h80, 8'h00, 1, 0, 'h080, 2, 0, 0);
    stepb("ret1",     RET,  8'h00, 8'h00, 1, 0, 'h041, 1, 0, 0);
    stepb("ret2",     RET,  8'h00, 8'h00, 1, 0, 'h011, 0, 0, 0);

    // Overflow: discard (m0) versus circular (m1)
    stepb("goto10b",  GOTO, 8'h10, 8'h00, 1, 0, 'h010, 0, 0, 0);
    stepb("call40b",  CALL, 8'h40, 8'h00, 1, 0, 'h040, 1, 0, 0);
    stepb("call80b",  CALL, 8'h80, 8'h00, 1, 0, 'h080, 2, 0, 0);
    step ("call_ovf", CALL, 8'hC0, 8'h00, 1, 0, 'h0C0, 2, 1, 0, 'h0C0, 2, 1, 0);
    step ("ovf_ret1", RET,  8'h00, 8'h00, 1, 0, 'h041, 1, 1, 0, 'h081, 1, 1, 0);
    step ("ovf_ret2", RET,  8'h00, 8'h00, 1, 0, 'h011, 0, 1, 0, 'h041, 0, 1, 0);
    step ("ovf_ret3", RET,  8'h00, 8'h00, 1, 0, 'h012, 0, 1, 1, 'h042, 0, 1, 1);
    step ("clr_all",  NOP,  8'h00, 8'h00, 1, 1, 'h013, 0, 0, 0, 'h043, 0, 0, 0);

    // Underflow and sticky clear
    stepb("goto20",   GOTO, 8'h20, 8'h00, 1, 0, 'h020, 0, 0, 0);
    stepb("unf",      RET,  8'h00, 8'h00, 1, 0, 'h021, 0, 0, 1);
    stepb("clr",      NOP,  8'h00, 8'h00, 1, 1, 'h022, 0, 0, 0);
    stepb("unf2",     RET,  8'h00, 8'h00, 1, 0, 'h023, 0, 0, 1);
    stepb("unf_clr",  RET,  8'h00, 8'h00, 1, 1, 'h024, 0, 0, 1);
    stepb("clr2",     NOP,  8'h00, 8'h00, 1, 1, 'h025, 0, 0, 0);

    // PC write and GOTO
    stepb("movf_pc",  12'h222, 8'h00, 8'h37, 1, 0, 'h037, 0, 0, 0);
    stepb("addwf_pc", 12'h1E2, 8'h00, 8'hFF, 1, 0, 'h0FF, 0, 0, 0);
    stepb("goto05",   12'hA05, 8'h05, 8'h00, 1, 0, 'h005, 0, 0, 0);

    // Stall with a CALL held on the bus
    stepb("call70",   CALL, 8'h70, 8'h00, 1, 0, 'h070, 1, 0, 0);
    stepb("stall1",   CALL, 8'h55, 8'h00, 0, 0, 'h070, 1, 0, 0);
    stepb("stall2",   CALL, 8'h55, 8'h00, 0, 0, 'h070, 1, 0, 0);
    stepb("stall3",   CALL, 8'h55, 8'h00, 0, 0, 'h070, 1, 0, 0);
    stepb("call55",   CALL, 8'h55, 8'h00, 1, 0, 'h055, 2, 0, 0);
    stepb("ret71",    RET,  8'h00, 8'h00, 1, 0, 'h071, 1, 0, 0);
    stepb("ret06",    RET,  8'h00, 8'h00, 1, 0, 'h006, 0, 0, 0);

    // Asynchronous reset mid-run with a stacked entry and a sticky flag
    stepb("call30",   CALL, 8'h30, 8'h00, 1, 0, 'h030, 1, 0, 0);
    stepb("call31",   CALL, 8'h31, 8'h00, 1, 0, 'h031, 2, 0, 0);
    stepb("ovf_pre",  CALL, 8'h32, 8'h00, 1, 0, 'h032, 2, 1, 0);
    #3 reset = 1'b1;
    #1 check_reset_state("reset_async");
    #2 reset = 1'b0;
    stepb("post_rst", NOP,  8'h00, 8'h00, 1, 0, 'h000, 0, 0, 0);
    stepb("post_unf", RET,  8'h00, 8'h00, 1, 0, 'h001, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
# pc_stack_seq

Parametrised program-counter sequencer for the 12-bit-instruction core, the successor to the fixed two-level PC block. It decodes branch, call, return and PC-write instructions and selects the next PC. Return addresses go on a configurable-depth hardware stack with selectable overflow policy, and stack status and error flags are exported. It sits between instruction fetch (drives the fetch address) and the decoder/ALU (supplies `inst`, `k`, `fin`).

## Interface
- `PC_W`, 11, PC width in bits (≥ 9).
- `K_W`, 8, literal/target width; zero-extended to `PC_W`.
- `FIN_W`, 8, width of the file-register PC-write value; zero-extended to `PC_W`.
- `DEPTH`, 2, return-stack entries (≥ 1).
- `OVF_MODE`, 0, overflow policy: 0 = discard push, 1 = circular (overwrite oldest).
- `RESET_VECTOR`, all ones (`PC_W` bits), PC value while in reset.

- `clk4`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 freezes all state.
- `inst`  in  12  current instruction.
- `k`  in  `K_W`  branch/call target literal.
- `fin`  in  `FIN_W`  value written to PC by a file-register op.
- `err_clr`  in  1  synchronous clear of sticky error flags.
- `pc`  out  `PC_W`  registered program counter.
- `level`  out  clog2(`DEPTH`+1)  current stack occupancy.
- `stack_full`  out  1  `level == DEPTH`.
- `stack_empty`  out  1  `level == 0`.
- `ovf_err`  out  1  sticky: push attempted while full.
- `unf_err`  out  1  sticky: pop attempted while empty.

## Operation
- Reset, asynchronous: `pc`=`RESET_VECTOR`, `level`=0, all stack entries 0, `ovf_err`=`unf_err`=0.
- Decode applies when `en`=1 and is mutually exclusive:
  - GOTO (`inst[11:9]`=101): next = zext(`k`).
  - CALL (`inst[11:8]`=1001): push `pc`+1, then next = zext(`k`).
  - RETLW (`inst[11:8]`=1000): next = top of stack, then pop.
  - PC write (`inst`=0x222 MOVF PC, or `inst`=0x1E2 ADDWF PC): next = zext(`fin`).
  - Otherwise: next = `pc`+1, modulo 2^`PC_W`. 0x7FF wraps to 0x000 at the default width.
- Stack is LIFO: push writes entry `level` and increments `level`; pop reads entry `level`−1 and decrements `level`.
- Push while full:
  - `OVF_MODE`=0: the push is dropped and contents are unchanged.
  - `OVF_MODE`=1: the oldest entry is discarded and the new entry becomes top. Implement as a ring pointer.
  - In both modes `level` stays at `DEPTH`, `ovf_err` is set, and the PC still jumps to `k`.
- Pop while empty: behaves as a NOP (next = `pc`+1), `level` stays 0, `unf_err` is set.
- Push/pop return-address width is `PC_W`; no truncation.
- `en`=0: `pc`, `level`, stack contents and flags all hold, regardless of `inst`. `err_clr` is still honoured.
- `err_clr`=1 clears both sticky flags on the next edge. If a new error occurs in the same cycle, set takes priority over clear.

## Timing
- `inst`, `k` and `fin` belong to the instruction at the current `pc`. The next-PC select is combinational from `inst`, `level` and the stack top.
- `pc`, `level` and flags update on the same `clk4` edge: one-cycle latency from `inst` to the new `pc`.
- `stack_full` and `stack_empty` are decoded from registered `level`; they carry no combinational path from `inst`.
- Reset asserted mid-operation forces outputs immediately, independent of the clock. The first edge after release uses the instruction at `RESET_VECTOR`, and the default path wraps to 0.
- No multicycle paths. The critical path is `inst` decode → stack read mux → `pc` D-input.

## Test plan
- Reset and wrap (defaults):
  - Assert `reset` mid-run → `pc`=0x7FF with no clock edge, `level`=0, flags 0.
  - Release, `inst`=0x000 → `pc` 0x000, 0x001, 0x002.
- Nested call/return, `DEPTH`=2:
  - At `pc`=0x010, CALL `k`=0x40 → 0x040, `level`=1.
  - CALL `k`=0x80 → 0x080, `stack_full`=1.
  - RETLW → 0x041.
  - RETLW → 0x011, `stack_empty`=1.
- Overflow, starting from the state after the second CALL above:
  - Third CALL `k`=0xC0 at 0x080 → 0x0C0, `ovf_err`=1, `level`=2.
  - Mode 0: RETLW → 0x041, then RETLW → 0x011.
  - Mode 1: RETLW → 0x081, then RETLW → 0x041, then RETLW → underflow.
- Underflow and clear:
  - RETLW at 0x020 with an empty stack → `pc`=0x021, `unf_err`=1.
  - `err_clr` pulse → `unf_err`=0 next cycle.
  - `err_clr` in the same cycle as another empty RETLW → `unf_err` stays 1.
- PC write and GOTO:
  - `inst`=0x222, `fin`=0x37 → `pc`=0x037.
  - `inst`=0x1E2, `fin`=0xFF → 0x0FF.
  - `inst`=0xA05, `k`=0x05 → 0x005.
- Stall: `en`=0 for 3 cycles with CALL `k`=0x55 applied → `pc`, `level` and stack unchanged. Raise `en` → `pc`=0x055, `level` increments.
